// File: rtl/tx_channel_arbiter.sv
// tx_channel_arbiter
// Shares the single transmit datapath between N_REQ requesters. It picks one
// requester, sends the one-cycle senal_tr start pulse, waits for tx_done, and
// then acks the owner. If tx_done does not arrive within TIMEOUT cycles it
// aborts with a timeout_err pulse. All outputs come straight from flops.
// Optional build macro TX_ARB_FIXED_PRIO_EN: when defined, the lowest index
// always wins and there is no round-robin pointer. When undefined (the
// default), arbitration is round-robin.
module tx_channel_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 1023,
  parameter int TO_W    = 10,
  localparam int IDX_W  = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] owner,
  output logic             senal_tr,
  input  logic             tx_done,
  output logic [N_REQ-1:0] ack,
  output logic             timeout_err,
  output logic             busy
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_GRANT   = 3'd1;
  localparam logic [2:0] ST_START   = 3'd2;
  localparam logic [2:0] ST_WAIT    = 3'd3;
  localparam logic [2:0] ST_RELEASE = 3'd4;

  localparam logic [N_REQ-1:0] ONE_HOT_0 = N_REQ'(1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0]  CNT_MAX   = {TO_W{1'b1}};
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_REQ - 1);

  // Returns {found, index} of the first set request at or after 'start',
  // scanning upward and wrapping from N_REQ-1 back to 0.
  function automatic logic [IDX_W:0] pick_winner(input logic [N_REQ-1:0] r,
                                                 input logic [IDX_W-1:0] start);
    logic             found;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] cand;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = IDX_W'((int'(start) + i) % N_REQ);
      if (!found && r[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return {found, idx};
  endfunction

  logic [2:0]       state_r, state_s;
  logic [N_REQ-1:0] grant_r, grant_s;
  logic [IDX_W-1:0] owner_r, owner_s;
  logic             senal_tr_r, senal_tr_s;
  logic [N_REQ-1:0] ack_r, ack_s;
  logic             timeout_err_r, timeout_err_s;
  logic             busy_r, busy_s;
  logic [TO_W-1:0]  cnt_r, cnt_s;
  logic [IDX_W-1:0] arb_start_s;
  logic [IDX_W:0]   pick_s;

`ifdef TX_ARB_FIXED_PRIO_EN
  assign arb_start_s = '0;
`else
  logic [IDX_W-1:0] rr_ptr_r, rr_ptr_s;
  assign arb_start_s = rr_ptr_r;
`endif

  assign pick_s = pick_winner(req, arb_start_s);

  // Next-state and next-output logic for the arbitration FSM.
  always_comb begin
    state_s       = state_r;
    grant_s       = grant_r;
    owner_s       = owner_r;
    senal_tr_s    = 1'b0;
    ack_s         = '0;
    timeout_err_s = 1'b0;
    cnt_s         = cnt_r;
`ifndef TX_ARB_FIXED_PRIO_EN
    rr_ptr_s      = rr_ptr_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (pick_s[IDX_W]) begin
          grant_s = ONE_HOT_0 << pick_s[IDX_W-1:0];
          owner_s = pick_s[IDX_W-1:0];
          state_s = ST_GRANT;
        end else begin
          grant_s = '0;
        end
      end
      ST_GRANT: begin
        // The requester may withdraw before the transfer starts.
        if (!req[owner_r]) begin
          grant_s = '0;
          state_s = ST_IDLE;
        end else begin
          senal_tr_s = 1'b1;
          state_s    = ST_START;
        end
      end
      ST_START: begin
        cnt_s   = '0;
        state_s = ST_WAIT;
      end
      ST_WAIT: begin
        // Completion has priority over a timeout in the same cycle.
        if (tx_done) begin
          ack_s   = ONE_HOT_0 << owner_r;
          state_s = ST_RELEASE;
        end else if (cnt_r == TO_LAST) begin
          timeout_err_s = 1'b1;
          state_s       = ST_RELEASE;
        end else if (cnt_r != CNT_MAX) begin
          cnt_s = cnt_r + TO_W'(1);
        end else begin
          cnt_s = cnt_r;
        end
      end
      ST_RELEASE: begin
        grant_s = '0;
`ifndef TX_ARB_FIXED_PRIO_EN
        rr_ptr_s = (owner_r == IDX_LAST) ? '0 : owner_r + IDX_W'(1);
`endif
        state_s = ST_IDLE;
      end
      default: begin
        grant_s = '0;
        state_s = ST_IDLE;
      end
    endcase
    busy_s = (state_s != ST_IDLE);
  end

  // State and output registers; reset drops any grant immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      grant_r       <= '0;
      owner_r       <= '0;
      senal_tr_r    <= 1'b0;
      ack_r         <= '0;
      timeout_err_r <= 1'b0;
      busy_r        <= 1'b0;
      cnt_r         <= '0;
    end else begin
      state_r       <= state_s;
      grant_r       <= grant_s;
      owner_r       <= owner_s;
      senal_tr_r    <= senal_tr_s;
      ack_r         <= ack_s;
      timeout_err_r <= timeout_err_s;
      busy_r        <= busy_s;
      cnt_r         <= cnt_s;
    end
  end

`ifndef TX_ARB_FIXED_PRIO_EN
  // Round-robin pointer, advanced past the owner when a transfer ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_r <= '0;
    end else begin
      rr_ptr_r <= rr_ptr_s;
    end
  end
`endif

  assign grant       = grant_r;
  assign owner       = owner_r;
  assign senal_tr    = senal_tr_r;
  assign ack         = ack_r;
  assign timeout_err = timeout_err_r;
  assign busy        = busy_r;

endmodule

// File: tb/tb_tx_channel_arbiter.sv
// tb_tx_channel_arbiter
// Drives request/transmit-done traffic into tx_channel_arbiter. Expected
// winners come from a transaction-level model: a rotating start pointer and
// a first-set-bit search. Expected timing comes from the cycle rules of the
// block (grant +1, start +2, ack = done+1, idle = done+2).
// The build macro TX_ARB_FIXED_PRIO_EN switches the model to fixed priority.
module tb_tx_channel_arbiter;
  localparam int TO = 8;
`ifdef TX_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tx_done;
  logic [3:0] req;
  logic [3:0] grant;
  logic [3:0] ack;
  logic [1:0] owner;
  logic       senal_tr;
  logic       timeout_err;
  logic       busy;

  int tests = 0;
  int fails = 0;
  int m_ptr = 0;

  // Results of the most recent do_txn call; cycle numbers are relative to the cycle req was applied.
  logic [3:0] t_g, t_a;
  logic [1:0] t_o;
  int t_gc, t_sc, t_np, t_ac, t_ec, t_ic, t_oh;

  always #5 clk = ~clk;

  tx_channel_arbiter #(.N_REQ(4), .TIMEOUT(TO), .TO_W(10)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .grant(grant), .owner(owner),
    .senal_tr(senal_tr), .tx_done(tx_done), .ack(ack),
    .timeout_err(timeout_err), .busy(busy)
  );

  // Reference arbiter: first requester at or after the pointer, with wrap-around.
  function automatic int m_pick(input logic [3:0] r, input int ptr);
    int start;
    start = FIXED ? 0 : ptr;
    for (int i = 0; i < 4; i++) begin
      if (((r >> ((start + i) % 4)) & 4'b0001) != 4'b0000) return (start + i) % 4;
    end
    return -1;
  endfunction

  task automatic m_done(input int w);
    if (!FIXED) m_ptr = (w + 1) % 4;
  endtask

  task automatic do_reset();
    req = 4'b0000; tx_done = 1'b0; rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    m_ptr = 0;
  endtask

  // Applies r and runs one transfer. tx_done is driven dly cycles after senal_tr (never when dly<0).
  // Observations only are recorded here; each test compares them itself.
  task automatic do_txn(input logic [3:0] r, input int dly, input bit hold);
    int cyc;
    bit fin;
    t_g = 4'b0000; t_o = 2'b00; t_a = 4'b0000;
    t_gc = -1; t_sc = -1; t_np = 0; t_ac = -1; t_ec = -1; t_ic = -1; t_oh = 0;
    fin = 1'b0; cyc = 0;
    req = r;
    while (!fin && cyc < 60) begin
      @(posedge clk); #1; cyc++;
      tx_done = 1'b0;
      if ($countones(grant) > 1 || $countones(ack) > 1) t_oh++;
      if (t_gc < 0 && grant != 4'b0000) begin t_gc = cyc; t_g = grant; t_o = owner; end
      if (senal_tr) begin t_np++; if (t_sc < 0) t_sc = cyc; end
      if (ack != 4'b0000) begin t_a = ack; t_ac = cyc; end
      if (timeout_err) t_ec = cyc;
      if ((ack != 4'b0000 || timeout_err) && !hold) req = req & ~t_g;
      if ((t_ac >= 0 || t_ec >= 0) && cyc > ((t_ac > t_ec) ? t_ac : t_ec) && grant == 4'b0000 && !busy) begin
        t_ic = cyc; fin = 1'b1;
      end
      if (!fin && dly >= 0 && t_sc >= 0 && cyc == t_sc + dly) tx_done = 1'b1;
    end
    tx_done = 1'b0;
  endtask

  task automatic test_reset();
    req = 4'b0000; tx_done = 1'b0; rst_n = 1'b0;
    #2;
    tests++; if ({grant, owner, senal_tr, ack, timeout_err, busy} !== 13'b0) begin
      fails++; $display("FAIL reset_outputs: got %b expected 0", {grant, owner, senal_tr, ack, timeout_err, busy}); end
    do_reset();
    repeat (3) @(posedge clk); #1;
    tests++; if ({grant, senal_tr, ack, timeout_err, busy} !== 11'b0) begin
      fails++; $display("FAIL idle_no_req: got %b expected 0", {grant, senal_tr, ack, timeout_err, busy}); end
  endtask

  task automatic test_basic();
    do_reset();
    do_txn(4'b0010, 5, 1'b0);
    m_done(1);
    tests++; if (t_g !== 4'b0010 || t_o !== 2'd1 || t_gc != 1) begin
      fails++; $display("FAIL basic_grant: got g=%b o=%0d cyc=%0d expected 0010/1/1", t_g, t_o, t_gc); end
    tests++; if (t_sc != 2 || t_np != 1) begin
      fails++; $display("FAIL basic_start: got cyc=%0d pulses=%0d expected 2/1", t_sc, t_np); end
    tests++; if (t_a !== 4'b0010 || t_ac != 8) begin
      fails++; $display("FAIL basic_ack: got %b at %0d expected 0010 at 8", t_a, t_ac); end
    tests++; if (t_ic != 9 || t_ec != -1) begin
      fails++; $display("FAIL basic_idle: got idle=%0d err=%0d expected 9/-1", t_ic, t_ec); end
  endtask

  task automatic test_round_robin();
    int w;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      w = m_pick(4'b1111, m_ptr);
      do_txn(4'b1111, 3, 1'b1);
      tests++; if (t_o !== 2'(FIXED ? 0 : k % 4) || t_g !== (4'b0001 << w) || t_a !== (4'b0001 << w)) begin
        fails++; $display("FAIL rr_order[%0d]: got o=%0d g=%b a=%b expected o=%0d", k, t_o, t_g, t_a, w); end
      m_done(w);
    end
    req = 4'b0000;
  endtask

  task automatic test_back_to_back();
    int sc1, ic1;
    do_reset();
    do_txn(4'b1111, 1, 1'b1);
    sc1 = t_sc; ic1 = t_ic;
    do_txn(4'b1111, 1, 1'b1);
    tests++; if ((ic1 - sc1) + t_sc != 5) begin
      fails++; $display("FAIL start_gap: got %0d expected 5", (ic1 - sc1) + t_sc); end
    req = 4'b0000;
  endtask

  task automatic test_wrap();
    int w;
    do_reset();
    do_txn(4'b0100, 2, 1'b0);
    m_done(2);
    w = m_pick(4'b1001, m_ptr);
    do_txn(4'b1001, 2, 1'b0);
    tests++; if (t_g !== (4'b0001 << w) || t_g !== (FIXED ? 4'b0001 : 4'b1000)) begin
      fails++; $display("FAIL wrap_first: got %b expected %b", t_g, 4'b0001 << w); end
    m_done(w);
    w = m_pick(4'b1001 & ~(4'b0001 << w), m_ptr);
    do_txn(4'b1001 & ~t_g, 2, 1'b0);
    tests++; if (t_g !== (4'b0001 << w)) begin
      fails++; $display("FAIL wrap_second: got %b expected %b", t_g, 4'b0001 << w); end
    m_done(w);
  endtask

  task automatic test_timeout();
    int w;
    do_reset();
    do_txn(4'b0100, -1, 1'b0);
    m_done(2);
    tests++; if (t_ec != 3 + TO || t_a !== 4'b0000) begin
      fails++; $display("FAIL timeout_err: got err=%0d ack=%b expected %0d/0000", t_ec, t_a, 3 + TO); end
    tests++; if (t_ic != 4 + TO || t_np != 1) begin
      fails++; $display("FAIL timeout_release: got idle=%0d pulses=%0d expected %0d/1", t_ic, t_np, 4 + TO); end
    w = m_pick(4'b1111, m_ptr);
    do_txn(4'b1111, 1, 1'b0);
    tests++; if (t_o !== 2'(w)) begin
      fails++; $display("FAIL timeout_ptr: got owner %0d expected %0d", t_o, w); end
    m_done(w);
    req = 4'b0000;
  endtask

  task automatic test_done_vs_timeout();
    do_reset();
    do_txn(4'b0001, TO, 1'b0);
    m_done(0);
    tests++; if (t_a !== 4'b0001 || t_ac != 3 + TO || t_ec != -1) begin
      fails++; $display("FAIL done_wins: got ack=%b at %0d err=%0d expected 0001 at %0d, -1", t_a, t_ac, t_ec, 3 + TO); end
  endtask

  task automatic test_grant_drop();
    int w, seen;
    do_reset();
    do_txn(4'b0100, 2, 1'b0);
    m_done(2);
    req = 4'b0100;
    @(posedge clk); #1;
    tests++; if (grant !== 4'b0100) begin
      fails++; $display("FAIL drop_grant: got %b expected 0100", grant); end
    req = 4'b0000;
    seen = 0;
    for (int c = 2; c < 10; c++) begin
      @(posedge clk); #1;
      tx_done = 1'b0;
      if (senal_tr || ack != 4'b0000 || timeout_err) seen++;
      if (c == 2) begin
        tests++; if (grant !== 4'b0000 || busy !== 1'b0) begin
          fails++; $display("FAIL drop_idle: got grant=%b busy=%b expected 0000/0", grant, busy); end
        tx_done = 1'b1;
      end
    end
    tests++; if (seen != 0) begin
      fails++; $display("FAIL drop_no_pulse: got %0d pulse cycles expected 0", seen); end
    w = m_pick(4'b1111, m_ptr);
    do_txn(4'b1111, 1, 1'b0);
    tests++; if (t_o !== 2'(w)) begin
      fails++; $display("FAIL drop_ptr_kept: got owner %0d expected %0d", t_o, w); end
    m_done(w);
    req = 4'b0000;
  endtask

  task automatic test_done_ignored();
    int first_ack;
    logic [3:0] ack_v;
    do_reset();
    first_ack = -1; ack_v = 4'b0000;
    req = 4'b0001; tx_done = 1'b1;
    for (int c = 1; c < 10; c++) begin
      @(posedge clk); #1;
      if (ack != 4'b0000 && first_ack < 0) begin first_ack = c; ack_v = ack; req = 4'b0000; end
      if (c == 3) tx_done = 1'b0;
      if (c == 6) tx_done = 1'b1;
      if (c == 7) tx_done = 1'b0;
    end
    m_done(0);
    tests++; if (first_ack != 7 || ack_v !== 4'b0001) begin
      fails++; $display("FAIL done_outside_wait: got ack=%b at %0d expected 0001 at 7", ack_v, first_ack); end
  endtask

  task automatic test_reset_mid_wait();
    int w, dly;
    logic [3:0] r;
    do_reset();
    req = 4'b0010;
    repeat (4) @(posedge clk);
    #1;
    tests++; if (busy !== 1'b1 || grant !== 4'b0010) begin
      fails++; $display("FAIL pre_reset_wait: got busy=%b grant=%b expected 1/0010", busy, grant); end
    #2 rst_n = 1'b0;
    #1;
    tests++; if ({grant, owner, senal_tr, ack, timeout_err, busy} !== 13'b0) begin
      fails++; $display("FAIL async_reset: got %b expected 0", {grant, owner, senal_tr, ack, timeout_err, busy}); end
    @(posedge clk); #1;
    tests++; if ({grant, ack, busy} !== 9'b0) begin
      fails++; $display("FAIL reset_held: got %b expected 0", {grant, ack, busy}); end
    rst_n = 1'b1; req = 4'b0000; m_ptr = 0;
    r = 4'($urandom_range(1, 15));
    dly = $urandom_range(1, 6);
    w = m_pick(r, m_ptr);
    do_txn(r, dly, 1'b0);
    tests++; if (t_g !== (4'b0001 << w) || t_a !== (4'b0001 << w) || t_ac != 3 + dly) begin
      fails++; $display("FAIL after_reset: got g=%b a=%b at %0d expected %b at %0d", t_g, t_a, t_ac, 4'b0001 << w, 3 + dly); end
    m_done(w);
    req = 4'b0000;
  endtask

  task automatic test_random();
    int w, dly;
    logic [3:0] pend;
    do_reset();
    pend = 4'b0000;
    for (int k = 0; k < 25; k++) begin
      pend = pend | 4'($urandom_range(0, 15));
      if (pend == 4'b0000) pend = 4'b1000;
      dly = $urandom_range(1, 6);
      w = m_pick(pend, m_ptr);
      do_txn(pend, dly, 1'b0);
      tests++; if (t_g !== (4'b0001 << w) || t_o !== 2'(w) || t_a !== (4'b0001 << w)) begin
        fails++; $display("FAIL rand_winner[%0d]: req=%b got g=%b o=%0d a=%b expected idx %0d", k, pend, t_g, t_o, t_a, w); end
      tests++; if (t_sc != 2 || t_np != 1 || t_ac != 3 + dly || t_ic != 4 + dly || t_oh != 0 || t_ec != -1) begin
        fails++; $display("FAIL rand_timing[%0d]: got s=%0d n=%0d a=%0d i=%0d oh=%0d e=%0d expected 2/1/%0d/%0d/0/-1",
                          k, t_sc, t_np, t_ac, t_ic, t_oh, t_ec, 3 + dly, 4 + dly); end
      m_done(w);
      pend = pend & ~(4'b0001 << w);
    end
    req = 4'b0000;
  endtask

  // Runs every scenario in order and prints the summary.
  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_back_to_back();
    test_wrap();
    test_timeout();
    test_done_vs_timeout();
    test_grant_drop();
    test_done_ignored();
    test_reset_mid_wait();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Upper bound on total run time.
  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

endmodule
